control_sequencer: RTL and testbench

Microcoded control sequencer for the 8-bit bus CPU, the consumer of the instruction register's 4-bit `opcode`. It drives every load, enable and count strobe on the shared bus, including the instruction register's `n_load` and `n_enable`. It steps through fetch (T1–T3) and a variable-length execute phase (T4–T6), and latches into a halt state on HLT. Control outputs are a combinational decode of the registered T-state, the `opcode` and the flags.

---
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 tb/tb_control_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit for the 8-bit bus CPU.
// Steps through fetch (T1-T3), then a variable-length execute (T4-T6) chosen
// by the 4-bit opcode. HLT parks the machine in HALT until clear.
// The T-state is registered. All control strobes are a combinational decode of
// that state, the opcode and the flags, and are forced inactive while clear is high.
//
// Ports:
//   clk, clear             clock, asynchronous active-high reset
//   opcode[3:0]            instruction register bits [7:4] (valid from T4)
//   carry_flag, zero_flag  registered ALU flags, sampled in T4 for JC/JZ
//   pc_*, mar_*, ram_*,    bus control strobes; *_n_* are active-low
//   ir_*, acc_*, b_*,
//   alu_*, flags_*, out_*
//   halt                   high while halted
//   t_state[2:0]           1..6 = T1..T6, 0 = HALT
module control_sequencer (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_inc,
    output logic       pc_n_enable,
    output logic       pc_n_load,
    output logic       mar_n_load,
    output logic       ram_n_enable,
    output logic       ir_n_load,
    output logic       ir_n_enable,
    output logic       acc_n_load,
    output logic       acc_n_enable,
    output logic       b_n_load,
    output logic       alu_n_enable,
    output logic       alu_sub,
    output logic       flags_n_load,
    output logic       out_n_load,
    output logic       halt,
    output logic [2:0] t_state
);

    // Encoding doubles as the t_state output value.
    typedef enum logic [2:0] {
        StHalt = 3'd0,
        StT1   = 3'd1,
        StT2   = 3'd2,
        StT3   = 3'd3,
        StT4   = 3'd4,
        StT5   = 3'd5,
        StT6   = 3'd6
    } state_e;

    localparam logic [3:0] OpLda = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpLdi = 4'b0101;
    localparam logic [3:0] OpJmp = 4'b0110;
    localparam logic [3:0] OpJc  = 4'b0111;
    localparam logic [3:0] OpJz  = 4'b1000;
    localparam logic [3:0] OpOut = 4'b1110;
    localparam logic [3:0] OpHlt = 4'b1111;

    state_e r_state;
    state_e w_state_next;
    logic   w_mem_op;
    logic   w_arith_op;
    logic   w_jump_taken;

    assign w_mem_op     = (opcode == OpLda) || (opcode == OpAdd) || (opcode == OpSub);
    assign w_arith_op   = (opcode == OpAdd) || (opcode == OpSub);
    assign w_jump_taken = (opcode == OpJmp) ||
                          ((opcode == OpJc) && carry_flag) ||
                          ((opcode == OpJz) && zero_flag);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= StT1;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StT1;
        case (r_state)
            StT1:    w_state_next = StT2;
            StT2:    w_state_next = StT3;
            StT3:    w_state_next = StT4;
            StT4: begin
                if (opcode == OpHlt) begin
                    w_state_next = StHalt;
                end else if (w_mem_op) begin
                    w_state_next = StT5;
                end else begin
                    w_state_next = StT1;
                end
            end
            StT5:    w_state_next = w_arith_op ? StT6 : StT1;
            StT6:    w_state_next = StT1;
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StT1;
        endcase
    end

    assign t_state = r_state;
    assign halt    = (r_state == StHalt);

    always_comb begin
        pc_inc       = 1'b0;
        pc_n_enable  = 1'b1;
        pc_n_load    = 1'b1;
        mar_n_load   = 1'b1;
        ram_n_enable = 1'b1;
        ir_n_load    = 1'b1;
        ir_n_enable  = 1'b1;
        acc_n_load   = 1'b1;
        acc_n_enable = 1'b1;
        b_n_load     = 1'b1;
        alu_n_enable = 1'b1;
        alu_sub      = 1'b0;
        flags_n_load = 1'b1;
        out_n_load   = 1'b1;
        // Clear masks everything, including the T1 strobes of the reset state.
        if (!clear) begin
            case (r_state)
                StT1: begin
                    pc_n_enable = 1'b0;
                    mar_n_load  = 1'b0;
                end
                StT2: pc_inc = 1'b1;
                StT3: begin
                    ram_n_enable = 1'b0;
                    ir_n_load    = 1'b0;
                end
                StT4: begin
                    if (w_mem_op) begin
                        ir_n_enable = 1'b0;
                        mar_n_load  = 1'b0;
                    end else if (opcode == OpLdi) begin
                        ir_n_enable = 1'b0;
                        acc_n_load  = 1'b0;
                    end else if (w_jump_taken) begin
                        ir_n_enable = 1'b0;
                        pc_n_load   = 1'b0;
                    end else if (opcode == OpOut) begin
                        acc_n_enable = 1'b0;
                        out_n_load   = 1'b0;
                    end
                end
                StT5: begin
                    ram_n_enable = 1'b0;
                    alu_sub      = (opcode == OpSub);
                    if (w_arith_op) begin
                        b_n_load = 1'b0;
                    end else begin
                        acc_n_load = 1'b0;
                    end
                end
                StT6: begin
                    alu_n_enable = 1'b0;
                    acc_n_load   = 1'b0;
                    flags_n_load = 1'b0;
                    alu_sub      = (opcode == OpSub);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench for control_sequencer.
// The stimulus process queues one expected output vector per clock, taken
// from an instruction-level model. The monitor pops one entry per falling
// edge and compares it with the DUT outputs.
module tb_control_sequencer;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_NOP = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef struct packed {
        logic [2:0] t;
        logic halt;
        logic pc_inc;
        logic pc_n_enable;
        logic pc_n_load;
        logic mar_n_load;
        logic ram_n_enable;
        logic ir_n_load;
        logic ir_n_enable;
        logic acc_n_load;
        logic acc_n_enable;
        logic b_n_load;
        logic alu_n_enable;
        logic alu_sub;
        logic flags_n_load;
        logic out_n_load;
    } outs_t;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic       pc_inc, pc_n_enable, pc_n_load, mar_n_load, ram_n_enable;
    logic       ir_n_load, ir_n_enable, acc_n_load, acc_n_enable, b_n_load;
    logic       alu_n_enable, alu_sub, flags_n_load, out_n_load, halt;
    logic [2:0] t_state;
    outs_t      act;

    control_sequencer dut (
        .clk          (clk),
        .clear        (clear),
        .opcode       (opcode),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
        .pc_inc       (pc_inc),
        .pc_n_enable  (pc_n_enable),
        .pc_n_load    (pc_n_load),
        .mar_n_load   (mar_n_load),
        .ram_n_enable (ram_n_enable),
        .ir_n_load    (ir_n_load),
        .ir_n_enable  (ir_n_enable),
        .acc_n_load   (acc_n_load),
        .acc_n_enable (acc_n_enable),
        .b_n_load     (b_n_load),
        .alu_n_enable (alu_n_enable),
        .alu_sub      (alu_sub),
        .flags_n_load (flags_n_load),
        .out_n_load   (out_n_load),
        .halt         (halt),
        .t_state      (t_state)
    );

    assign act = {t_state, halt, pc_inc, pc_n_enable, pc_n_load, mar_n_load, ram_n_enable,
                  ir_n_load, ir_n_enable, acc_n_load, acc_n_enable, b_n_load, alu_n_enable,
                  alu_sub, flags_n_load, out_n_load};

    always #5 clk = ~clk;

    outs_t exp_q[$];
    string tag_q[$];
    int    n_pass = 0;
    int    n_total = 0;

    // All strobes inactive, with a given step number and halt level.
    function automatic outs_t idle_vec(input int t, input logic h);
        outs_t e;
        e = '1;
        e.t = 3'(t);
        e.halt = h;
        e.pc_inc = 1'b0;
        e.alu_sub = 1'b0;
        return e;
    endfunction

    // Number of clocks an instruction takes, fetch included.
    function automatic int instr_len(input logic [3:0] op);
        if (op == OP_ADD || op == OP_SUB) return 6;
        if (op == OP_LDA) return 5;
        return 4;
    endfunction

    // Expected strobes for step 1..6 of an instruction.
    function automatic outs_t model(input int step, input logic [3:0] op,
                                    input logic c, input logic z);
        outs_t e;
        logic  mem_op, arith, jump;
        e      = idle_vec(step, 1'b0);
        mem_op = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
        arith  = (op == OP_ADD) || (op == OP_SUB);
        jump   = (op == OP_JMP) || (op == OP_JC && c) || (op == OP_JZ && z);
        case (step)
            1: begin e.pc_n_enable = 1'b0; e.mar_n_load = 1'b0; end
            2: e.pc_inc = 1'b1;
            3: begin e.ram_n_enable = 1'b0; e.ir_n_load = 1'b0; end
            4: begin
                if (mem_op) begin
                    e.ir_n_enable = 1'b0; e.mar_n_load = 1'b0;
                end else if (op == OP_LDI) begin
                    e.ir_n_enable = 1'b0; e.acc_n_load = 1'b0;
                end else if (jump) begin
                    e.ir_n_enable = 1'b0; e.pc_n_load = 1'b0;
                end else if (op == OP_OUT) begin
                    e.acc_n_enable = 1'b0; e.out_n_load = 1'b0;
                end
            end
            5: begin
                e.ram_n_enable = 1'b0;
                if (arith) e.b_n_load = 1'b0;
                else e.acc_n_load = 1'b0;
                e.alu_sub = (op == OP_SUB);
            end
            6: begin
                e.alu_n_enable = 1'b0;
                e.acc_n_load = 1'b0;
                e.flags_n_load = 1'b0;
                e.alu_sub = (op == OP_SUB);
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic drive_cycle(input logic [3:0] op, input logic c, input logic z,
                               input logic clr, input outs_t e, input string tag);
        @(posedge clk);
        #1;
        opcode = op;
        carry_flag = c;
        zero_flag = z;
        clear = clr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Fetch cycles carry a random (irrelevant) opcode; c4/z4 are the T4 flags.
    task automatic run_instr(input logic [3:0] op, input logic c4, input logic z4,
                             input string tag);
        logic [3:0] o;
        logic       c, z;
        for (int s = 1; s <= instr_len(op); s++) begin
            o = (s >= 4) ? op : 4'($urandom);
            c = (s == 4) ? c4 : 1'($urandom);
            z = (s == 4) ? z4 : 1'($urandom);
            drive_cycle(o, c, z, 1'b0, model(s, o, c, z), $sformatf("%s.T%0d", tag, s));
        end
    endtask

    outs_t mon_e;
    string mon_tag;
    logic [4:0] mon_drv;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            n_total++;
            if (act === mon_e) n_pass++;
            else $display("FAIL %s: outputs got %b want %b", mon_tag, act, mon_e);
            mon_drv = ~{pc_n_enable, ram_n_enable, ir_n_enable, acc_n_enable, alu_n_enable};
            n_total++;
            if ($countones(mon_drv) <= 1) n_pass++;
            else $display("FAIL %s.bus: drivers got %b want at most one", mon_tag, mon_drv);
        end
    end

    initial begin
        logic [3:0] op;
        #2 clear = 1'b1;
        for (int i = 0; i < 3; i++)
            drive_cycle(4'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                        idle_vec(1, 1'b0), "reset");

        run_instr(OP_NOP, 1'b0, 1'b0, "nop");
        run_instr(OP_NOP, 1'b1, 1'b1, "nop2");
        run_instr(OP_ADD, 1'b0, 1'b0, "add");
        run_instr(OP_SUB, 1'b1, 1'b0, "sub");
        run_instr(OP_LDA, 1'b0, 1'b1, "lda");
        run_instr(OP_JC,  1'b1, 1'b0, "jc_taken");
        run_instr(OP_JC,  1'b0, 1'b1, "jc_not");
        run_instr(OP_JZ,  1'b0, 1'b1, "jz_taken");
        run_instr(OP_JZ,  1'b1, 1'b0, "jz_not");
        run_instr(OP_LDI, 1'b0, 1'b0, "ldi");
        run_instr(OP_JMP, 1'b0, 1'b0, "jmp");
        run_instr(OP_OUT, 1'b1, 1'b1, "out");
        run_instr(4'b0011, 1'b1, 1'b1, "nop3");
        run_instr(4'b1101, 1'b1, 1'b1, "nop13");

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 14));
            run_instr(op, 1'($urandom), 1'($urandom), $sformatf("rnd%0d_op%h", i, op));
        end

        // Asynchronous clear in the middle of ADD T5.
        for (int s = 1; s <= 4; s++)
            drive_cycle(OP_ADD, 1'b0, 1'b0, 1'b0, model(s, OP_ADD, 1'b0, 1'b0),
                        $sformatf("abort.T%0d", s));
        @(posedge clk);
        #1 opcode = OP_ADD;
        #2 clear = 1'b1;
        exp_q.push_back(idle_vec(1, 1'b0));
        tag_q.push_back("abort.clear");
        drive_cycle(OP_ADD, 1'b0, 1'b0, 1'b1, idle_vec(1, 1'b0), "abort.hold");
        run_instr(OP_ADD, 1'b0, 1'b0, "restart");

        // HLT: park for 20 clocks, then leave via clear.
        run_instr(OP_HLT, 1'b1, 1'b1, "hlt");
        for (int i = 0; i < 20; i++)
            drive_cycle(4'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                        idle_vec(0, 1'b1), $sformatf("halt%0d", i));
        drive_cycle(OP_HLT, 1'b0, 1'b0, 1'b1, idle_vec(1, 1'b0), "halt_clear");
        run_instr(OP_NOP, 1'b0, 1'b0, "post_halt");

        @(posedge clk);
        @(negedge clk);
        #1;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: pending got %0d want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
